alu_issue_seq: RTL and testbench

Multi-cycle execute-stage sequencer that drives the combinational ALU as its initiator. It accepts an R-type or I-type ALU instruction plus source register values over a valid/ready handshake. It decodes the instruction into an `ALU_Ops` code and prepared operands, drives the ALU's `a`/`b`/`func_op` inputs, and captures the ALU's `y` output. It then returns the result and destination register on a second valid/ready handshake toward writeback.

---
 rtl/alu_issue_seq_pkg.sv | 57 +++++
 rtl/alu_op_decode.sv | 81 ++++++++
 rtl/alu_issue_seq.sv | 110 +++++++++++
 tb/tb_alu_issue_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_seq_pkg.sv
// Shared types and constants for the ALU issue sequencer and the ALU it drives.
// Holds the ALU_Ops encoding, RV32I opcode/funct fields and the sequencer FSM state.
package alu_issue_seq_pkg;

  typedef enum logic [3:0] {
    AddOp  = 4'd0,
    SubOp  = 4'd1,
    SllOp  = 4'd2,
    SltOp  = 4'd3,
    SltuOp = 4'd4,
    XorOp  = 4'd5,
    SrlOp  = 4'd6,
    SraOp  = 4'd7,
    OrOp   = 4'd8,
    AndOp  = 4'd9
  } ALU_Ops;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  // alt selects the funct7=0100000 variant (SUB / SRA) where one exists.
  function automatic ALU_Ops f3_to_op(input logic [2:0] f3, input logic alt);
    ALU_Ops op;
    case (f3)
      F3_ADD_SUB: op = alt ? SubOp : AddOp;
      F3_SLL:     op = SllOp;
      F3_SLT:     op = SltOp;
      F3_SLTU:    op = SltuOp;
      F3_XOR:     op = XorOp;
      F3_SRL_SRA: op = alt ? SraOp : SrlOp;
      F3_OR:      op = OrOp;
      default:    op = AndOp;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I OP / OP-IMM decoder producing ALU op, operands and illegal flag.
// LUI decoding is included only when ALU_ISSUE_LUI_EN is defined.
module alu_op_decode
  import alu_issue_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output ALU_Ops                op,
  output logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] b,
  output logic [4:0]            rd,
  output logic                  illegal
);

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic                  f7_base;
  logic                  f7_alt;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] shamt;
  logic                  unused_rs1_idx;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign rd      = instr[11:7];
  assign f7_base = (funct7 == F7_BASE);
  assign f7_alt  = (funct7 == F7_ALT);
  assign imm_i   = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
  assign shamt   = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};
  // Register indices are resolved upstream; the rs1 field is not needed here.
  assign unused_rs1_idx = ^instr[19:15];

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    op      = AddOp;
    a       = '0;
    b       = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        a       = rs1_data;
        b       = rs2_data;
        op      = f3_to_op(funct3, f7_alt);
        illegal = !(f7_base || (f7_alt && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA)));
      end
      OPC_OP_IMM: begin
        a = rs1_data;
        b = imm_i;
        // No SUBI: funct3 000 ignores the upper immediate bits entirely.
        op = f3_to_op(funct3, 1'b0);
        if (funct3 == F3_SLL) begin
          b       = shamt;
          illegal = !f7_base;
        end else if (funct3 == F3_SRL_SRA) begin
          b       = shamt;
          op      = f3_to_op(funct3, f7_alt);
          illegal = !(f7_base || f7_alt);
        end
      end
`ifdef ALU_ISSUE_LUI_EN
      OPC_LUI: begin
        op = AddOp;
        a  = '0;
        b  = {instr[31:12], {(DATA_WIDTH-20){1'b0}}};
      end
`endif
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      op = AddOp;
      a  = '0;
      b  = '0;
    end
  end

endmodule

// File: rtl/alu_issue_seq.sv
// Execute-stage sequencer: accepts an ALU instruction, drives an external combinational
// ALU and returns its result to writeback. Optional LUI support: ALU_ISSUE_LUI_EN.
module alu_issue_seq
  import alu_issue_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           instr_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  output ALU_Ops                alu_op_o,
  input  logic [DATA_WIDTH-1:0] alu_y_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [4:0]            rd_o,
  output logic                  illegal_o
);

  seq_state_e            state_q;
  seq_state_e            state_d;
  logic [31:0]           instr_q;
  logic [DATA_WIDTH-1:0] rs1_q;
  logic [DATA_WIDTH-1:0] rs2_q;

  ALU_Ops                dec_op;
  logic [DATA_WIDTH-1:0] dec_a;
  logic [DATA_WIDTH-1:0] dec_b;
  logic [4:0]            dec_rd;
  logic                  dec_illegal;

  alu_op_decode #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_decode (
    .instr    (instr_q),
    .rs1_data (rs1_q),
    .rs2_data (rs2_q),
    .op       (dec_op),
    .a        (dec_a),
    .b        (dec_b),
    .rd       (dec_rd),
    .illegal  (dec_illegal)
  );

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i) state_d = DECODE;
      DECODE:  state_d = dec_illegal ? DONE : EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      instr_q   <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      alu_a_o   <= '0;
      alu_b_o   <= '0;
      alu_op_o  <= AddOp;
      result_o  <= '0;
      rd_o      <= '0;
      illegal_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            instr_q <= instr_i;
            rs1_q   <= rs1_data_i;
            rs2_q   <= rs2_data_i;
          end
        end
        DECODE: begin
          alu_a_o   <= dec_a;
          alu_b_o   <= dec_b;
          alu_op_o  <= dec_op;
          rd_o      <= dec_rd;
          illegal_o <= dec_illegal;
          // Illegal instructions skip EXEC, so the result is cleared here instead.
          if (dec_illegal) result_o <= '0;
        end
        EXEC:    result_o <= alu_y_i;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed, table-driven bench for alu_issue_seq with a behavioural ALU on its outputs.
// LUI expectations follow ALU_ISSUE_LUI_EN.
module tb_alu_issue_seq;
  import alu_issue_seq_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    ALU_Ops      exp_op;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_result;
    logic [4:0]  exp_rd;
    logic        exp_illegal;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  ALU_Ops      alu_op;
  logic [31:0] alu_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  rd;
  logic        illegal;

  int total;
  int bad;

  alu_issue_seq #(
    .DATA_WIDTH(32)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .instr_i     (instr),
    .rs1_data_i  (rs1),
    .rs2_data_i  (rs2),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_op_o    (alu_op),
    .alu_y_i     (alu_y),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .rd_o        (rd),
    .illegal_o   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the combinational ALU the sequencer drives.
  always_comb begin
    alu_y = '0;
    case (alu_op)
      AddOp:  alu_y = alu_a + alu_b;
      SubOp:  alu_y = alu_a - alu_b;
      SllOp:  alu_y = alu_a << alu_b[4:0];
      SltOp:  alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
      SltuOp: alu_y = {31'b0, alu_a < alu_b};
      XorOp:  alu_y = alu_a ^ alu_b;
      SrlOp:  alu_y = alu_a >> alu_b[4:0];
      SraOp:  alu_y = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      OrOp:   alu_y = alu_a | alu_b;
      AndOp:  alu_y = alu_a & alu_b;
      default: alu_y = '0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] i, input logic [31:0] r1,
                              input logic [31:0] r2, input ALU_Ops op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res, input logic [4:0] d,
                              input logic ill);
    vec_t v;
    v.name = name; v.instr = i; v.rs1 = r1; v.rs2 = r2; v.exp_op = op;
    v.exp_a = a; v.exp_b = b; v.exp_result = res; v.exp_rd = d; v.exp_illegal = ill;
    return v;
  endfunction

  // One full instruction: accept, check per-cycle timing, check outputs, retire.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    check({v.name, ".in_ready_idle"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    instr    = v.instr;
    rs1      = v.rs1;
    rs2      = v.rs2;
    @(negedge clk);
    in_valid = 1'b0;
    check({v.name, ".valid_decode"}, {31'b0, out_valid}, 32'd0);
    check({v.name, ".ready_decode"}, {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    check({v.name, ".op"}, {28'b0, alu_op}, {28'b0, v.exp_op});
    check({v.name, ".a"}, alu_a, v.exp_a);
    check({v.name, ".b"}, alu_b, v.exp_b);
    check({v.name, ".rd"}, {27'b0, rd}, {27'b0, v.exp_rd});
    if (v.exp_illegal) begin
      check({v.name, ".valid_t2"}, {31'b0, out_valid}, 32'd1);
    end else begin
      check({v.name, ".valid_t2"}, {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      check({v.name, ".valid_t3"}, {31'b0, out_valid}, 32'd1);
    end
    check({v.name, ".result"}, result, v.exp_result);
    check({v.name, ".illegal"}, {31'b0, illegal}, {31'b0, v.exp_illegal});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({v.name, ".valid_after"}, {31'b0, out_valid}, 32'd0);
    check({v.name, ".ready_after"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = '0;
    rs1       = '0;
    rs2       = '0;

    vecs.push_back(mk("add",     32'h002081B3, 32'd5,        32'd7,        AddOp,  32'd5,        32'd7,        32'd12,       5'd3,  1'b0));
    vecs.push_back(mk("srai",    32'h4040D213, 32'hF0000000, 32'h0,        SraOp,  32'hF0000000, 32'd4,        32'hFF000000, 5'd4,  1'b0));
    vecs.push_back(mk("addi_m1", 32'hFFF08313, 32'd1,        32'h0,        AddOp,  32'd1,        32'hFFFFFFFF, 32'd0,        5'd6,  1'b0));
    vecs.push_back(mk("sub",     32'h402083B3, 32'd10,       32'd3,        SubOp,  32'd10,       32'd3,        32'd7,        5'd7,  1'b0));
    vecs.push_back(mk("slt",     32'h0020A433, 32'hFFFFFFFF, 32'd1,        SltOp,  32'hFFFFFFFF, 32'd1,        32'd1,        5'd8,  1'b0));
    vecs.push_back(mk("sltu",    32'h0020B433, 32'hFFFFFFFF, 32'd1,        SltuOp, 32'hFFFFFFFF, 32'd1,        32'd0,        5'd8,  1'b0));
    vecs.push_back(mk("xori",    32'h0F00C493, 32'h000000FF, 32'h0,        XorOp,  32'h000000FF, 32'h000000F0, 32'h0000000F, 5'd9,  1'b0));
    vecs.push_back(mk("slli31",  32'h01F09513, 32'd1,        32'h0,        SllOp,  32'd1,        32'd31,       32'h80000000, 5'd10, 1'b0));
    vecs.push_back(mk("srl",     32'h0020D5B3, 32'h80000000, 32'h24,       SrlOp,  32'h80000000, 32'h24,       32'h08000000, 5'd11, 1'b0));
    vecs.push_back(mk("and",     32'h0020F633, 32'hF0F0F0F0, 32'hFF00FF00, AndOp,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'd12, 1'b0));
    vecs.push_back(mk("ori_neg", 32'hFF00E693, 32'h0000000F, 32'h0,        OrOp,   32'h0000000F, 32'hFFFFFFF0, 32'hFFFFFFFF, 5'd13, 1'b0));
    vecs.push_back(mk("ill_f7",  32'h022081B3, 32'd5,        32'd7,        AddOp,  32'd0,        32'd0,        32'd0,        5'd3,  1'b1));
    vecs.push_back(mk("add2",    32'h002081B3, 32'd100,      32'd23,       AddOp,  32'd100,      32'd23,       32'd123,      5'd3,  1'b0));
    vecs.push_back(mk("ill_sli", 32'h41F09513, 32'd1,        32'h0,        AddOp,  32'd0,        32'd0,        32'd0,        5'd10, 1'b1));
    vecs.push_back(mk("and2",    32'h0020F633, 32'hFFFFFFFF, 32'h0000ABCD, AndOp,  32'hFFFFFFFF, 32'h0000ABCD, 32'h0000ABCD, 5'd12, 1'b0));
    vecs.push_back(mk("ill_opc", 32'h00000000, 32'd5,        32'd7,        AddOp,  32'd0,        32'd0,        32'd0,        5'd0,  1'b1));
    vecs.push_back(mk("srai2",   32'h4040D213, 32'h70000000, 32'h0,        SraOp,  32'h70000000, 32'd4,        32'h07000000, 5'd4,  1'b0));
`ifdef ALU_ISSUE_LUI_EN
    vecs.push_back(mk("lui",     32'h123452B7, 32'hDEADBEEF, 32'h0,        AddOp,  32'd0,        32'h12345000, 32'h12345000, 5'd5,  1'b0));
`else
    vecs.push_back(mk("lui",     32'h123452B7, 32'hDEADBEEF, 32'h0,        AddOp,  32'd0,        32'd0,        32'd0,        5'd5,  1'b1));
`endif

    // Reset state, sampled while reset is still asserted.
    #12;
    check("rst.in_ready", {31'b0, in_ready}, 32'd1);
    check("rst.out_valid", {31'b0, out_valid}, 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.op", {28'b0, alu_op}, {28'b0, AddOp});
    check("rst.illegal", {31'b0, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Back-pressure: DONE holds for 5 cycles while new input is offered and ignored.
    @(negedge clk);
    in_valid = 1'b1; instr = 32'h002081B3; rs1 = 32'd5; rs2 = 32'd7;
    @(negedge clk);
    instr = 32'h0020F633; rs1 = 32'h0; rs2 = 32'h0;
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check("bp.valid", {31'b0, out_valid}, 32'd1);
      check("bp.result", result, 32'd12);
      check("bp.in_ready", {31'b0, in_ready}, 32'd0);
      check("bp.op", {28'b0, alu_op}, {28'b0, AddOp});
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp.release_ready", {31'b0, in_ready}, 32'd1);
    check("bp.release_valid", {31'b0, out_valid}, 32'd0);

    // Reset pulse while in EXEC, then a fresh instruction.
    @(negedge clk);
    in_valid = 1'b1; instr = 32'h402083B3; rs1 = 32'd9; rs2 = 32'd1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("exec.a_before_rst", alu_a, 32'd9);
    rst_n = 1'b0;
    #1;
    check("exec_rst.in_ready", {31'b0, in_ready}, 32'd1);
    check("exec_rst.out_valid", {31'b0, out_valid}, 32'd0);
    check("exec_rst.a", alu_a, 32'd0);
    check("exec_rst.b", alu_b, 32'd0);
    check("exec_rst.op", {28'b0, alu_op}, {28'b0, AddOp});
    check("exec_rst.result", result, 32'd0);
    check("exec_rst.rd", {27'b0, rd}, 32'd0);
    check("exec_rst.illegal", {31'b0, illegal}, 32'd0);
    @(negedge clk);
    check("exec_rst.valid_held", {31'b0, out_valid}, 32'd0);
    rst_n = 1'b1;
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
